seg7_scan_decoder: RTL and testbench
====================================

SEG7_SCAN_DECODER -- requirements
Module: seg7_scan_decoder

Interface
REQ-001 Parameter STABLE_CYCLES, default 4: consecutive identical samples required before a digit is accepted (legal range 2..255).
REQ-002 Parameter TIMEOUT_CYCLES, default 100000: maximum cycles from the first digit of a frame to frame completion (legal range 16..2^20).
REQ-003 Port clk  input  1  single clock; all logic rising-edge.
REQ-004 Port rst  input  1  reset, asynchronous, active-high.
REQ-005 Port an  input  4  anode enables, active-low; bit i selects digit i.
REQ-006 Port seg  input  7  segments, active-low; seg[0]=a ... seg[6]=g.
REQ-007 Port digits  output  16  decoded frame; digits[4i+3:4i] holds digit i.
REQ-008 Port digit_err  output  4  bit i high means digit i pattern was unrecognised.
REQ-009 Port frame_valid  output  1  one-cycle pulse when digits/digit_err are updated.
REQ-010 Port frame_timeout  output  1  one-cycle pulse when a partial frame is abandoned.

Function
REQ-011 an and seg SHALL pass through one input register stage; all decisions use the registered sample.
REQ-012 Pattern table (seg, active-low): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000; blank 1111111 decodes to 4'hF with err=0.
REQ-013 Any other seg pattern SHALL decode to 4'hE with err=1.
REQ-014 A sample is eligible only when the registered an has exactly one bit low.
REQ-015 Stability counter SHALL increment, saturating at STABLE_CYCLES, while the sample is eligible and equal to the previous sample; otherwise it SHALL reload to 1 if eligible, else 0.
REQ-016 A digit SHALL be captured on the cycle the counter first reaches STABLE_CYCLES; no recapture until the counter reloads (one capture per dwell).
REQ-017 A capture SHALL write the decoded value and err into a pending buffer slot i and set capture-mask bit i; recapturing an already-set slot overwrites that slot.
REQ-018 State machine: IDLE (mask empty) -> COLLECT on first capture -> DONE when mask==4'b1111 -> IDLE next cycle.
REQ-019 In DONE, digits and digit_err SHALL load from the pending buffer and frame_valid SHALL pulse for that one cycle; mask clears.
REQ-020 Latency: frame_valid asserts exactly 1 cycle after the capture that completes the mask.
REQ-021 A capture occurring in the DONE cycle SHALL be applied to the new, cleared mask, not lost.
REQ-022 Timeout counter SHALL start at 0 on the IDLE->COLLECT transition and increment in COLLECT; on reaching TIMEOUT_CYCLES, frame_timeout SHALL pulse, mask clears, state returns to IDLE; digits unchanged.
REQ-023 frame_valid and frame_timeout SHALL never assert in the same cycle.
REQ-024 Multiple-low or all-high an (blanking, ghosting) SHALL never capture and SHALL reset stability only, not the frame.

Reset
REQ-025 While rst is high: digits=16'h0000, digit_err=4'b0000, frame_valid=0, frame_timeout=0, state=IDLE, mask=0, all counters 0, input register=all ones.
REQ-026 Reset asserted mid-frame SHALL discard the partial frame; first capture after release requires a full STABLE_CYCLES dwell.

Structure
REQ-027 Shared package SHALL hold the ten digit segment constants, SEG_BLANK, DEC_BLANK=4'hF, DEC_INVALID=4'hE and the state enumeration; the existing hex-to-segment encoder uses the same constants.
REQ-028 One sub-module, seg7_to_hex (purely combinational seg -> {err, value[3:0]}), SHALL be instantiated once on the registered sample.

Verification
REQ-029 Scan digits 3,2,1,0 with patterns for 1,2,3,4, each held 8 cycles -> frame_valid once, digits=16'h1234, digit_err=0.
REQ-030 Digit 0 held only 3 cycles (STABLE_CYCLES=4), others normal -> no capture of digit 0, no frame_valid until digit 0 later held 4 cycles.
REQ-031 Digit 2 shows 1010101, others valid -> digits[11:8]=4'hE, digit_err=4'b0100; blank on digit 3 -> digits[15:12]=4'hF, err bit 3=0.
REQ-032 TIMEOUT_CYCLES=50, scan only digits 0 and 1 -> frame_timeout pulses 50 cycles after first capture, digits keep prior value.
REQ-033 an=4'b0011 or 4'b1111 between digits, plus glitch pulses -> no captures during those cycles, frame still completes correctly.
REQ-034 Assert rst after 3 digits captured, release, rescan 4 digits -> outputs zero during reset, single frame_valid with new digits only.

Source files
------------

// File: rtl/seg7_scan_decoder_pkg.sv
// Shared seven-segment constants (active-low, seg[6:0] = g..a) and the
// frame-collector state encoding used by the scan decoder and the encoder.
package seg7_scan_decoder_pkg;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [3:0] DEC_BLANK   = 4'hF;
  localparam logic [3:0] DEC_INVALID = 4'hE;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_DONE    = 2'd2
  } state_e;

  // Hex-to-segment encoder; anything outside 0..9 shows blank.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] value);
    logic [6:0] pat;
    case (value)
      4'd0:    pat = SEG_0;
      4'd1:    pat = SEG_1;
      4'd2:    pat = SEG_2;
      4'd3:    pat = SEG_3;
      4'd4:    pat = SEG_4;
      4'd5:    pat = SEG_5;
      4'd6:    pat = SEG_6;
      4'd7:    pat = SEG_7;
      4'd8:    pat = SEG_8;
      4'd9:    pat = SEG_9;
      default: pat = SEG_BLANK;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/seg7_scan_decoder_to_hex.sv
// Combinational segment-pattern decoder: seg (active-low) -> {err, value}.
module seg7_to_hex
  import seg7_scan_decoder_pkg::*;
(
  input  logic [6:0] seg_i,
  output logic [3:0] value_o,
  output logic       err_o
);

  // Pattern lookup; unknown shapes flag an error and report DEC_INVALID.
  always_comb begin
    value_o = DEC_INVALID;
    err_o   = 1'b0;
    case (seg_i)
      SEG_0:     value_o = 4'd0;
      SEG_1:     value_o = 4'd1;
      SEG_2:     value_o = 4'd2;
      SEG_3:     value_o = 4'd3;
      SEG_4:     value_o = 4'd4;
      SEG_5:     value_o = 4'd5;
      SEG_6:     value_o = 4'd6;
      SEG_7:     value_o = 4'd7;
      SEG_8:     value_o = 4'd8;
      SEG_9:     value_o = 4'd9;
      SEG_BLANK: value_o = DEC_BLANK;
      default: begin
        value_o = DEC_INVALID;
        err_o   = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Recovers a 4-digit frame by sniffing a multiplexed 7-segment display bus:
// debounces each digit dwell, buffers captures and publishes complete frames.
module seg7_scan_decoder
  import seg7_scan_decoder_pkg::*;
#(
  parameter int STABLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  an,
  input  logic [6:0]  seg,
  output logic [15:0] digits,
  output logic [3:0]  digit_err,
  output logic        frame_valid,
  output logic        frame_timeout
);

  localparam logic [7:0]  STABLE_C = 8'(STABLE_CYCLES);
  localparam logic [20:0] TMO_LAST = 21'(TIMEOUT_CYCLES - 1);

  logic [3:0]  an_q;
  logic [6:0]  seg_q;
  logic [10:0] prev_q;
  logic [7:0]  stab_q, stab_d;
  logic [15:0] buf_val_q, buf_val_d;
  logic [3:0]  buf_err_q, buf_err_d;
  logic [3:0]  mask_q;
  logic [20:0] tmo_q;
  state_e      state_q;
  logic [15:0] digits_q;
  logic [3:0]  digit_err_q;
  logic        frame_valid_q, frame_timeout_q;

  logic        eligible_s, cap_s;
  logic [1:0]  idx_s;
  logic [3:0]  dec_val_s, cap_mask_s, mask_or_s;
  logic        dec_err_s;

  seg7_to_hex u_dec (
    .seg_i   (seg_q),
    .value_o (dec_val_s),
    .err_o   (dec_err_s)
  );

  // Input sample stage plus the previous sample for the stability compare.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an_q   <= 4'b1111;
      seg_q  <= 7'b1111111;
      prev_q <= 11'h7FF;
      stab_q <= 8'd0;
    end else begin
      an_q   <= an;
      seg_q  <= seg;
      prev_q <= {an_q, seg_q};
      stab_q <= stab_d;
    end
  end

  // Exactly one low anode makes the sample eligible and names the digit slot.
  always_comb begin
    eligible_s = 1'b0;
    idx_s      = 2'd0;
    case (an_q)
      4'b1110: begin eligible_s = 1'b1; idx_s = 2'd0; end
      4'b1101: begin eligible_s = 1'b1; idx_s = 2'd1; end
      4'b1011: begin eligible_s = 1'b1; idx_s = 2'd2; end
      4'b0111: begin eligible_s = 1'b1; idx_s = 2'd3; end
      default: begin eligible_s = 1'b0; idx_s = 2'd0; end
    endcase
  end

  // Stability counter and single capture per dwell, at the first arrival at STABLE.
  always_comb begin
    stab_d = 8'd0;
    if (eligible_s && ({an_q, seg_q} == prev_q)) begin
      if (stab_q == STABLE_C) begin
        stab_d = stab_q;
      end else begin
        stab_d = stab_q + 8'd1;
      end
    end else if (eligible_s) begin
      stab_d = 8'd1;
    end else begin
      stab_d = 8'd0;
    end
    cap_s      = (stab_d == STABLE_C) && (stab_q != STABLE_C);
    cap_mask_s = cap_s ? (4'b0001 << idx_s) : 4'b0000;
    mask_or_s  = mask_q | cap_mask_s;
  end

  // Pending buffer next-state; captures overwrite their slot.
  always_comb begin
    buf_val_d = buf_val_q;
    buf_err_d = buf_err_q;
    if (cap_s) begin
      buf_val_d[{idx_s, 2'b00} +: 4] = dec_val_s;
      buf_err_d[idx_s]               = dec_err_s;
    end else begin
      buf_val_d = buf_val_q;
      buf_err_d = buf_err_q;
    end
  end

  // Pending buffer storage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_val_q <= 16'h0000;
      buf_err_q <= 4'b0000;
    end else begin
      buf_val_q <= buf_val_d;
      buf_err_q <= buf_err_d;
    end
  end

  // Frame collector FSM; outputs load on entry to DONE so they show during DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      mask_q          <= 4'b0000;
      tmo_q           <= 21'd0;
      digits_q        <= 16'h0000;
      digit_err_q     <= 4'b0000;
      frame_valid_q   <= 1'b0;
      frame_timeout_q <= 1'b0;
    end else begin
      frame_valid_q   <= 1'b0;
      frame_timeout_q <= 1'b0;
      case (state_q)
        ST_IDLE, ST_DONE: begin
          tmo_q <= 21'd0;
          if (cap_s) begin
            mask_q  <= cap_mask_s;
            state_q <= ST_COLLECT;
          end else begin
            mask_q  <= 4'b0000;
            state_q <= ST_IDLE;
          end
        end
        ST_COLLECT: begin
          // Completion wins over an expiring timeout in the same cycle.
          if (mask_or_s == 4'b1111) begin
            state_q       <= ST_DONE;
            mask_q        <= 4'b0000;
            tmo_q         <= 21'd0;
            digits_q      <= buf_val_d;
            digit_err_q   <= buf_err_d;
            frame_valid_q <= 1'b1;
          end else if (tmo_q == TMO_LAST) begin
            state_q         <= ST_IDLE;
            mask_q          <= 4'b0000;
            tmo_q           <= 21'd0;
            frame_timeout_q <= 1'b1;
          end else begin
            mask_q <= mask_or_s;
            tmo_q  <= tmo_q + 21'd1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          mask_q  <= 4'b0000;
          tmo_q   <= 21'd0;
        end
      endcase
    end
  end

  assign digits        = digits_q;
  assign digit_err     = digit_err_q;
  assign frame_valid   = frame_valid_q;
  assign frame_timeout = frame_timeout_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed bench for seg7_scan_decoder (STABLE_CYCLES=4, TIMEOUT_CYCLES=50).
module tb_seg7_scan_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic [15:0] digits;
  logic [3:0]  digit_err;
  logic        frame_valid;
  logic        frame_timeout;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0, fv_cnt = 0, ft_cnt = 0, both_cnt = 0, fv_cycle = 0, ft_cycle = 0;
  int c0 = 0, base_fv = 0, base_ft = 0;
  logic [15:0] fv_digits = 16'h0000;
  logic [3:0]  fv_err = 4'b0000;

  localparam logic [3:0] AN0 = 4'b1110, AN1 = 4'b1101, AN2 = 4'b1011, AN3 = 4'b0111;
  localparam logic [3:0] AN_OFF = 4'b1111, AN_GHOST = 4'b0011;
  localparam logic [6:0] P_BLANK = 7'b1111111, P_BAD = 7'b1010101;
  logic [6:0] pat [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                           7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

  always #5 clk = ~clk;

  seg7_scan_decoder #(.STABLE_CYCLES(4), .TIMEOUT_CYCLES(50)) dut (
    .clk           (clk),
    .rst           (rst),
    .an            (an),
    .seg           (seg),
    .digits        (digits),
    .digit_err     (digit_err),
    .frame_valid   (frame_valid),
    .frame_timeout (frame_timeout)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive a/s for n clock edges, logging output pulses sampled 1ns after each edge.
  task automatic hold(input logic [3:0] a, input logic [6:0] s, input int n);
    an  = a;
    seg = s;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      cyc++;
      if (frame_valid) begin
        fv_cnt++;
        fv_cycle  = cyc;
        fv_digits = digits;
        fv_err    = digit_err;
      end
      if (frame_timeout) begin
        ft_cnt++;
        ft_cycle = cyc;
      end
      if (frame_valid && frame_timeout) both_cnt++;
    end
  endtask

  initial begin
    rst = 1'b1;
    an  = AN_OFF;
    seg = P_BLANK;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_digits", 32'(digits), 32'h0);
    check_eq("rst_err", 32'(digit_err), 32'h0);
    check_eq("rst_fv", 32'(frame_valid), 32'h0);
    check_eq("rst_ft", 32'(frame_timeout), 32'h0);
    rst = 1'b0;
    hold(AN_OFF, P_BLANK, 4);

    // Basic frame 1234 and completion latency.
    hold(AN3, pat[1], 8);
    hold(AN2, pat[2], 8);
    hold(AN1, pat[3], 8);
    c0 = cyc;
    hold(AN0, pat[4], 8);
    hold(AN_OFF, P_BLANK, 4);
    check_eq("basic_count", 32'(fv_cnt), 32'd1);
    check_eq("basic_digits", 32'(fv_digits), 32'h1234);
    check_eq("basic_err", 32'(fv_err), 32'h0);
    check_eq("basic_latency", 32'(fv_cycle), 32'(c0 + 5));

    // Short dwell on digit 0 must not capture.
    base_fv = fv_cnt;
    hold(AN3, pat[9], 8);
    hold(AN2, pat[8], 8);
    hold(AN1, pat[7], 8);
    hold(AN0, pat[6], 3);
    hold(AN_OFF, P_BLANK, 2);
    check_eq("short_no_frame", 32'(fv_cnt), 32'(base_fv));
    hold(AN0, pat[6], 8);
    hold(AN_OFF, P_BLANK, 4);
    check_eq("short_count", 32'(fv_cnt), 32'(base_fv + 1));
    check_eq("short_digits", 32'(fv_digits), 32'h9876);

    // Invalid pattern on digit 2, blank on digit 3.
    hold(AN3, P_BLANK, 8);
    hold(AN2, P_BAD, 8);
    hold(AN1, pat[7], 8);
    hold(AN0, pat[9], 8);
    hold(AN_OFF, P_BLANK, 4);
    check_eq("bad_digits", 32'(fv_digits), 32'hFE79);
    check_eq("bad_err", 32'(fv_err), 32'h4);

    // Timeout with only digits 0 and 1 scanned.
    base_fv = fv_cnt;
    base_ft = ft_cnt;
    c0 = cyc;
    hold(AN0, pat[5], 8);
    hold(AN1, pat[3], 8);
    hold(AN_OFF, P_BLANK, 60);
    check_eq("tmo_count", 32'(ft_cnt), 32'(base_ft + 1));
    check_eq("tmo_cycle", 32'(ft_cycle), 32'(c0 + 55));
    check_eq("tmo_no_frame", 32'(fv_cnt), 32'(base_fv));
    check_eq("tmo_digits_kept", 32'(digits), 32'hFE79);

    // Ghosting, blanking and glitches between and within dwells.
    base_fv = fv_cnt;
    hold(AN3, pat[4], 8);
    hold(AN_GHOST, pat[8], 2);
    hold(AN_OFF, P_BLANK, 2);
    hold(AN2, pat[0], 2);
    hold(AN2, pat[3], 8);
    hold(AN_GHOST, pat[8], 2);
    hold(AN1, pat[2], 3);
    hold(AN_OFF, pat[2], 1);
    hold(AN1, pat[2], 3);
    hold(AN_OFF, P_BLANK, 2);
    hold(AN0, pat[1], 8);
    check_eq("glitch_no_early", 32'(fv_cnt), 32'(base_fv));
    hold(AN1, pat[2], 8);
    hold(AN_OFF, P_BLANK, 4);
    check_eq("glitch_count", 32'(fv_cnt), 32'(base_fv + 1));
    check_eq("glitch_digits", 32'(fv_digits), 32'h4321);

    // Reset mid-frame discards the partial frame.
    hold(AN3, pat[9], 8);
    hold(AN2, pat[9], 8);
    hold(AN1, pat[9], 8);
    rst = 1'b1;
    #1;
    check_eq("mid_rst_digits", 32'(digits), 32'h0);
    check_eq("mid_rst_err", 32'(digit_err), 32'h0);
    check_eq("mid_rst_fv", 32'(frame_valid), 32'h0);
    check_eq("mid_rst_ft", 32'(frame_timeout), 32'h0);
    hold(AN1, pat[9], 3);
    rst = 1'b0;
    base_fv = fv_cnt;
    hold(AN0, pat[8], 8);
    hold(AN_OFF, P_BLANK, 2);
    check_eq("rst_discard", 32'(fv_cnt), 32'(base_fv));
    hold(AN3, pat[5], 8);
    hold(AN2, pat[6], 8);
    hold(AN1, pat[7], 8);
    hold(AN_OFF, P_BLANK, 4);
    check_eq("rst_count", 32'(fv_cnt), 32'(base_fv + 1));
    check_eq("rst_digits_new", 32'(fv_digits), 32'h5678);

    check_eq("no_overlap", 32'(both_cnt), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
